// File: rtl/aes_block_packetizer.sv
// Re-frames each 128-bit encrypted block as USB-style data packets:
// SYNC, PID, payload, CRC16 low/high, then EOP and an idle gap.
module aes_block_packetizer #(
  parameter int         DATA_BYTES = 1,
  parameter logic [7:0] SYNC_BYTE  = 8'h80,
  parameter int         EOP_CYCLES = 3,
  parameter int         GAP_CYCLES = 1
) (
  input  logic         tb_clk,
  input  logic         tb_n_rst,
  input  logic [127:0] block_in,
  input  logic         block_valid,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         eop,
  output logic         busy,
  output logic         overrun
);

  localparam logic [4:0]  BYTE_MASK   = 5'(DATA_BYTES - 1);
  localparam logic [4:0]  BLOCK_BYTES = 5'd16;
  localparam logic [15:0] EOP_LOAD    = 16'(EOP_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD    = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam logic [7:0]  PID_DATA0   = 8'hC3;
  localparam logic [7:0]  PID_DATA1   = 8'h4B;
  localparam logic [15:0] CRC_POLY    = 16'hA001;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_GAP
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   shift_q, shift_d;
  logic [15:0]    crc_q, crc_d;
  logic [4:0]     byte_cnt_q, byte_cnt_d;
  logic [15:0]    cyc_cnt_q, cyc_cnt_d;
  logic           pid_q, pid_d;
  logic           overrun_q, overrun_d;
  logic           busy_q, busy_d;
  logic [7:0]     byte_out_q, byte_out_d;
  logic           byte_valid_q, byte_valid_d;
  logic           eop_q, eop_d;

  logic           xfer;
  logic           accept;
  logic [4:0]     byte_cnt_inc;
  state_e         after_gap_state;
  logic [15:0]    crc_stage [0:8];

  assign xfer            = byte_valid_q & byte_ready;
  // A block is taken only in IDLE with no start already pending.
  assign accept          = (state_q == S_IDLE) & ~busy_q & block_valid;
  assign byte_cnt_inc    = byte_cnt_q + 5'd1;
  assign after_gap_state = (byte_cnt_q == BLOCK_BYTES) ? S_IDLE : S_SYNC;

  // Reflected CRC16, one full payload byte per DATA transfer, LSB first.
  assign crc_stage[0] = crc_q ^ {8'h00, shift_q[127:120]};
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_crc
      assign crc_stage[gi+1] = crc_stage[gi][0] ? ({1'b0, crc_stage[gi][15:1]} ^ CRC_POLY)
                                                : {1'b0, crc_stage[gi][15:1]};
    end
  endgenerate

  always_ff @(posedge tb_clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      crc_q        <= '0;
      byte_cnt_q   <= '0;
      cyc_cnt_q    <= '0;
      pid_q        <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      byte_out_q   <= 8'hFF;
      byte_valid_q <= 1'b0;
      eop_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      byte_cnt_q   <= byte_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      pid_q        <= pid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      eop_q        <= eop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    byte_cnt_d = byte_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    pid_d      = pid_q;
    overrun_d  = overrun_q | (block_valid & ~accept);
    case (state_q)
      S_IDLE: begin
        if (busy_q) begin
          state_d = S_SYNC;
        end else if (accept) begin
          shift_d    = block_in;
          byte_cnt_d = '0;
        end
      end
      S_SYNC: begin
        if (xfer) begin
          state_d = S_PID;
          crc_d   = 16'hFFFF;
        end
      end
      S_PID: begin
        if (xfer) state_d = S_DATA;
      end
      S_DATA: begin
        if (xfer) begin
          crc_d      = crc_stage[8];
          shift_d    = shift_q << 8;
          byte_cnt_d = byte_cnt_inc;
          if ((byte_cnt_inc & BYTE_MASK) == 5'd0) state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (xfer) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        if (xfer) begin
          state_d   = S_EOP;
          cyc_cnt_d = EOP_LOAD;
          pid_d     = ~pid_q;
        end
      end
      S_EOP: begin
        if (cyc_cnt_q == 16'd0) begin
          if (GAP_CYCLES > 0) begin
            state_d   = S_GAP;
            cyc_cnt_d = GAP_LOAD;
          end else begin
            state_d = after_gap_state;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (cyc_cnt_q == 16'd0) state_d = after_gap_state;
        else                    cyc_cnt_d = cyc_cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs follow the next state so a transfer presents the following byte without a bubble.
  always_comb begin
    byte_out_d   = 8'hFF;
    byte_valid_d = 1'b0;
    eop_d        = (state_d == S_EOP);
    busy_d       = (state_d != S_IDLE) | accept;
    case (state_d)
      S_SYNC: begin
        byte_out_d   = SYNC_BYTE;
        byte_valid_d = 1'b1;
      end
      S_PID: begin
        byte_out_d   = pid_d ? PID_DATA1 : PID_DATA0;
        byte_valid_d = 1'b1;
      end
      S_DATA: begin
        byte_out_d   = shift_d[127:120];
        byte_valid_d = 1'b1;
      end
      S_CRC_LO: begin
        byte_out_d   = ~crc_d[7:0];
        byte_valid_d = 1'b1;
      end
      S_CRC_HI: begin
        byte_out_d   = ~crc_d[15:8];
        byte_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign eop        = eop_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
